// File: rtl/polar_fir_tap_accumulator.sv
// ============================================================================
//  Module   : polar_fir_tap_accumulator
//  Purpose  : Sums NUM_TAPS signed tap products per block, rounds half up,
//             scales by FRAC_SHIFT and emits one sample on a valid/ready port.
//             Define POLAR_FIR_ACC_SAT_EN to clamp instead of wrap the output.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module polar_fir_tap_accumulator #(
  parameter int PROD_W     = 36,
  parameter int ACC_W      = 44,
  parameter int NUM_TAPS   = 16,
  parameter int FRAC_SHIFT = 11,
  parameter int OUT_W      = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              err,
  input  logic              err_clr
);

  localparam int CNT_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam int RND_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] C_LAST_TAP = CNT_W'(NUM_TAPS - 1);
  localparam logic [RND_W-1:0] C_HALF     = RND_W'(1) << (FRAC_SHIFT - 1);

  logic [ACC_W-1:0]        r_acc;
  logic [CNT_W-1:0]        r_tap_cnt;
  logic                    r_out_valid;
  logic [OUT_W-1:0]        r_out_data;
  logic                    r_out_sat;
  logic                    r_err;

  logic                    w_last_tap;
  logic                    w_final_tap;
  logic                    w_accept;
  logic                    w_end_blk;
  logic [ACC_W-1:0]        w_sum;
  logic [RND_W-1:0]        w_rnd;
  logic signed [RND_W-1:0] w_shift;
  logic [OUT_W-1:0]        w_out_d;
  logic                    w_out_s;

  assign w_last_tap  = (r_tap_cnt == C_LAST_TAP);
  assign w_final_tap = in_last | w_last_tap;

  // Only a block-ending tap needs the output slot, so partial sums keep
  // accumulating while the consumer stalls.
  assign in_ready  = ce & ~(r_out_valid & ~out_ready & w_final_tap);
  assign w_accept  = in_valid & in_ready;
  assign w_end_blk = w_accept & w_final_tap;

  assign w_sum   = r_acc + {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  // One extra bit keeps the rounding increment from overflowing a full sum.
  assign w_rnd   = {w_sum[ACC_W-1], w_sum} + C_HALF;
  assign w_shift = $signed(w_rnd) >>> FRAC_SHIFT;

`ifdef POLAR_FIR_ACC_SAT_EN
  logic [RND_W-OUT_W:0] w_hi;
  logic                 w_fits;

  assign w_hi    = w_shift[RND_W-1:OUT_W-1];
  assign w_fits  = (&w_hi) | ~(|w_hi);
  assign w_out_d = w_fits ? w_shift[OUT_W-1:0]
                 : (w_shift[RND_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}});
  assign w_out_s = ~w_fits;
`else
  logic w_unused_hi;

  assign w_out_d     = w_shift[OUT_W-1:0];
  assign w_out_s     = 1'b0;
  assign w_unused_hi = ^w_shift[RND_W-1:OUT_W];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc       <= '0;
      r_tap_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_err       <= 1'b0;
    end else if (ce) begin
      if (w_end_blk) begin
        r_acc      <= '0;
        r_tap_cnt  <= '0;
        r_out_data <= w_out_d;
        r_out_sat  <= w_out_s;
      end else if (w_accept) begin
        r_acc     <= w_sum;
        r_tap_cnt <= r_tap_cnt + CNT_W'(1);
      end

      if (w_end_blk) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_accept && (in_last != w_last_tap)) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign err       = r_err;

endmodule

`default_nettype wire
